// File: rtl/switch_mode_decoder.sv
// switch_mode_decoder
// Debounces a six-bit front-panel switch word, commits stable words, and
// decodes them into a mode code plus TX/REM enables. A req/ack handshake
// tells the consumer that a new word has been committed. Commits arriving
// while a request is outstanding are coalesced into that request.
//
// Optional feature macro: SWITCH_MODE_CHG_COUNT_EN
//   defined   -> chg_count counts commits since reset, saturating at 16'hFFFF
//   undefined -> chg_count is tied to zero and no counter is built
module switch_mode_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sw,
  input  logic        mode_ack,
  output logic [1:0]  mode_code,
  output logic        tx_en,
  output logic        rem_en,
  output logic        mode_err,
  output logic        mode_req,
  output logic [15:0] chg_count
);

  // The stable counter saturates here; reaching it means the word has been
  // seen unchanged for long enough to be trusted.
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STABLE  = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  sw_q;
  logic [15:0] stable_cnt;
  logic [5:0]  committed;
  logic        commit;

  // True when exactly one of the four mode select bits is set.
  function automatic logic mode_is_onehot(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

  // Maps a one-hot mode field (bit3 = mode 1 ... bit0 = mode C) to its code.
  function automatic logic [1:0] mode_encode(input logic [3:0] m);
    logic [1:0] code;
    code = 2'd0;
    case (m)
      4'b1000: code = 2'd0;
      4'b0100: code = 2'd1;
      4'b0010: code = 2'd2;
      4'b0001: code = 2'd3;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

  // Saturating 16-bit increment for the commit counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sample the switch word and count how long it has stayed unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q       <= 6'd0;
      stable_cnt <= 16'd0;
    end else begin
      sw_q <= sw;
      if (sw != sw_q) begin
        stable_cnt <= 16'd0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + 16'd1;
      end
    end
  end

  // A word is committed once it is stable and actually new; the first commit
  // after reset always counts, even if it matches the reset value.
  assign commit = (stable_cnt == CNT_MAX) && (sw == sw_q) &&
                  ((sw_q != committed) || (state == IDLE));

  // Load the committed word and decoded outputs on a commit. An illegal mode
  // field flags mode_err but leaves the previous mode_code in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      committed <= 6'd0;
      mode_code <= 2'd0;
      tx_en     <= 1'b0;
      rem_en    <= 1'b0;
      mode_err  <= 1'b1;
    end else if (commit) begin
      committed <= sw_q;
      tx_en     <= sw_q[1];
      rem_en    <= sw_q[0];
      if (mode_is_onehot(sw_q[5:2])) begin
        mode_code <= mode_encode(sw_q[5:2]);
        mode_err  <= 1'b0;
      end else begin
        mode_err  <= 1'b1;
      end
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a commit always (re)arms the request; an ack only
  // retires it when no new commit lands on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (commit) state_nxt = PENDING;
      end
      STABLE: begin
        if (commit) state_nxt = PENDING;
      end
      PENDING: begin
        if (!commit && mode_ack) state_nxt = STABLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mode_req = (state == PENDING);

`ifdef SWITCH_MODE_CHG_COUNT_EN
  logic [15:0] chg_cnt_r;

  // Count commits since reset, holding at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      chg_cnt_r <= 16'd0;
    end else if (commit) begin
      chg_cnt_r <= sat_inc16(chg_cnt_r);
    end
  end

  assign chg_count = chg_cnt_r;
`else
  assign chg_count = 16'd0;
`endif

endmodule

// File: doc/switch_mode_decoder.md
SWITCH_MODE_DECODER -- requirements
Module: switch_mode_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive identical samples required before a switch word is committed; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port sw, input, 6 bits: switch word, already synchronized into the clk domain; bit5 mode 1, bit4 mode 2, bit3 mode 3/A, bit2 mode C, bit1 TX, bit0 REM.
REQ-005 SHALL have port mode_ack, input, 1 bit: consumer acknowledge of mode_req.
REQ-006 SHALL have port mode_code, output, 2 bits: committed mode; 0 = mode 1, 1 = mode 2, 2 = mode 3/A, 3 = mode C.
REQ-007 SHALL have ports tx_en and rem_en, outputs, 1 bit each: committed TX and REM switch states.
REQ-008 SHALL have port mode_err, output, 1 bit: the committed word has zero or more than one mode bit set.
REQ-009 SHALL have port mode_req, output, 1 bit: a new committed word awaits acknowledgement.
REQ-010 SHALL have port chg_count, output, 16 bits: number of commits since reset (see Configuration).

Function
REQ-011 SHALL register sw every cycle into sw_q and keep a stable counter: cleared to 0 when sw != sw_q, else incremented, saturating at DEBOUNCE_CYCLES-1.
REQ-012 SHALL commit sw_q when the stable counter equals DEBOUNCE_CYCLES-1, sw == sw_q, and sw_q differs from the last committed word; commit updates all outputs on that same edge.
REQ-013 SHALL make a word held constant from edge E0 (first edge sampling it) visible at outputs after edge E0+DEBOUNCE_CYCLES; any change in between restarts the count with no commit.
REQ-014 SHALL, on commit with exactly one of bits 5:2 set, load mode_code with the matching code and clear mode_err.
REQ-015 SHALL, on commit with zero or multiple mode bits set, set mode_err and hold mode_code at its previous value; tx_en and rem_en update regardless.
REQ-016 SHALL implement a three-state FSM: IDLE (nothing committed since reset), STABLE (committed, acknowledged), PENDING (mode_req=1).
REQ-017 SHALL move IDLE->PENDING and STABLE->PENDING on commit; PENDING->STABLE on a cycle with mode_ack=1 and no commit.
REQ-018 SHALL, on a commit while PENDING, update outputs and stay PENDING (coalesce); simultaneous mode_ack and commit keeps mode_req=1.
REQ-019 SHALL ignore mode_ack when mode_req=0.
REQ-020 SHALL treat the first commit after reset as a change even when the word equals the reset committed value 6'b000000.

Reset
REQ-021 SHALL, when rst=1 at a rising edge, set sw_q=0, stable counter=0, committed word=0, mode_code=0, tx_en=0, rem_en=0, mode_err=1, mode_req=0, chg_count=0, FSM=IDLE.
REQ-022 SHALL discard any in-progress debounce on reset; counting restarts from the first edge with rst=0.

Configuration
REQ-023 SHALL, with macro SWITCH_MODE_CHG_COUNT_EN defined, increment chg_count by one on every commit, saturating at 16'hFFFF.
REQ-024 SHALL, without SWITCH_MODE_CHG_COUNT_EN, keep the chg_count port and drive it constant 0 with no counter logic.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 SHALL cover: reset, then sw=6'b100010 held -> after E0+4: mode_code=0, tx_en=1, mode_err=0, mode_req=1; chg_count=1 with macro.
REQ-026 SHALL cover: sw toggles 6'b010000/6'b001000 every 2 cycles for 20 cycles -> no commit, outputs and mode_req unchanged.
REQ-027 SHALL cover: sw=6'b110000 held -> mode_err=1, mode_code holds previous value, mode_req=1.
REQ-028 SHALL cover: PENDING, mode_ack=1 on the same edge as a commit of 6'b000100 -> mode_req stays 1, mode_code=3; next lone ack -> mode_req=0.
REQ-029 SHALL cover: rst=1 for one cycle 2 cycles into a debounce -> all REQ-021 values; the word commits 4 edges after rst falls, not earlier.
REQ-030 SHALL cover: build without SWITCH_MODE_CHG_COUNT_EN, 3 commits -> chg_count=0 throughout.
